// File: rtl/sipo_status_rx_if.sv
// Bundle between the status-link serializer side and the SIPO receiver.
// master: link/consumer side; slave: the receiver.
interface sipo_status_rx_if #(
    parameter int WIDTH = 24
);
    logic                       serial_in;
    logic                       bit_valid;
    logic                       frame_tgl;
    logic                       out_ready;
    logic [WIDTH-1:0]           data_out;
    logic                       out_valid;
    logic                       overrun;
    logic                       frame_err;
    logic [$clog2(WIDTH+1)-1:0] bit_cnt;

    modport master (
        output serial_in, bit_valid, frame_tgl, out_ready,
        input  data_out, out_valid, overrun, frame_err, bit_cnt
    );

    modport slave (
        input  serial_in, bit_valid, frame_tgl, out_ready,
        output data_out, out_valid, overrun, frame_err, bit_cnt
    );
endinterface

// File: rtl/sipo_status_rx.sv
// Serial-in/parallel-out status word receiver, LSB first, valid/ready output.
// Optional frame resync on frame_tgl edges when SIPO_RESYNC_EN is defined.
module sipo_status_rx #(
    parameter int WIDTH = 24
) (
    input  logic             sys_clk,
    input  logic             rst,
    sipo_status_rx_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Output FSM: EMPTY = no unconsumed word, FULL = data_out holds an unconsumed word
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] word_w;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic             toggle_w;
    logic             complete_w;

`ifdef SIPO_RESYNC_EN
    logic frame_tgl_q;
    logic frame_err_q;

    assign toggle_w = (bus.frame_tgl != frame_tgl_q);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            frame_tgl_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_tgl_q <= bus.frame_tgl;
            if (toggle_w && (cnt_q != '0)) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    assign toggle_w      = 1'b0;
    assign bus.frame_err = 1'b0;
`endif

    // Word including the bit being captured this cycle
    always_comb begin
        word_w         = shift_q;
        word_w[cnt_q]  = bus.serial_in;
    end

    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        complete_w = 1'b0;
        if (toggle_w) begin
            shift_d = '0;
            cnt_d   = '0;
            if (bus.bit_valid) begin
                shift_d[0] = bus.serial_in;
                cnt_d      = CW'(1);
            end
        end else if (bus.bit_valid) begin
            if (cnt_q == LAST) begin
                complete_w = 1'b1;
                data_d     = word_w;
                shift_d    = '0;
                cnt_d      = '0;
            end else begin
                shift_d = word_w;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        case (state_q)
            EMPTY: begin
                if (complete_w) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (complete_w) begin
                    state_d = FULL;
                    if (!bus.out_ready) begin
                        overrun_d = 1'b1;
                    end
                end else if (bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            shift_q   <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.out_valid = (state_q == FULL);
    assign bus.overrun   = overrun_q;
    assign bus.bit_cnt   = cnt_q;
endmodule

// File: tb/tb_sipo_status_rx.sv
// Directed self-checking bench for sipo_status_rx; expectations are hand-computed.
module tb_sipo_status_rx;
    localparam int WIDTH = 24;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   errors  = 0;
    int   checks  = 0;
    int   valid_cycles = 0;

    sipo_status_rx_if #(.WIDTH(WIDTH)) bus ();

    sipo_status_rx #(.WIDTH(WIDTH)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (bus.out_valid === 1'b1) valid_cycles++;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends n bits of w LSB first; optional 3-cycle gap after every 5th bit;
    // optional out_ready rise on the edge that captures the last bit.
    task automatic send_bits(input logic [WIDTH-1:0] w, input int n,
                             input bit gap, input bit ready_last);
        for (int i = 0; i < n; i++) begin
            bus.serial_in = w[i];
            bus.bit_valid = 1'b1;
            if (ready_last && i == n - 1) bus.out_ready = 1'b1;
            tick();
            if (gap && (i % 5 == 4) && (i < n - 1)) begin
                bus.bit_valid = 1'b0;
                repeat (3) tick();
            end
        end
        bus.bit_valid = 1'b0;
        bus.serial_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.serial_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus.frame_tgl = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_data", 64'(bus.data_out), 64'h0);
        check("rst_valid", 64'(bus.out_valid), 64'h0);
        check("rst_overrun", 64'(bus.overrun), 64'h0);
        check("rst_frame_err", 64'(bus.frame_err), 64'h0);
        check("rst_bit_cnt", 64'(bus.bit_cnt), 64'h0);

        // Basic word
        bus.out_ready = 1'b1;
        valid_cycles  = 0;
        send_bits(24'hA5C3F0, 23, 1'b0, 1'b0);
        check("basic_cnt23", 64'(bus.bit_cnt), 64'd23);
        check("basic_not_yet_valid", 64'(bus.out_valid), 64'h0);
        send_bits(24'h000000 | (24'hA5C3F0 >> 23), 1, 1'b0, 1'b0);
        check("basic_valid", 64'(bus.out_valid), 64'h1);
        check("basic_data", 64'(bus.data_out), 64'hA5C3F0);
        check("basic_bit_cnt", 64'(bus.bit_cnt), 64'h0);
        tick();
        tick();
        check("basic_valid_clear", 64'(bus.out_valid), 64'h0);
        check("basic_valid_cycles", 64'(valid_cycles), 64'd1);

        // Gapped strobe
        valid_cycles = 0;
        send_bits(24'h123456, 24, 1'b1, 1'b0);
        check("gap_data", 64'(bus.data_out), 64'h123456);
        tick();
        tick();
        check("gap_valid_cycles", 64'(valid_cycles), 64'd1);

        // Backpressure
        bus.out_ready = 1'b0;
        send_bits(24'h000001, 24, 1'b0, 1'b0);
        check("bp_first_overrun", 64'(bus.overrun), 64'h0);
        send_bits(24'hFFFFFE, 24, 1'b0, 1'b0);
        check("bp_data", 64'(bus.data_out), 64'hFFFFFE);
        check("bp_valid", 64'(bus.out_valid), 64'h1);
        check("bp_overrun", 64'(bus.overrun), 64'h1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_valid_after", 64'(bus.out_valid), 64'h0);
        check("bp_overrun_sticky", 64'(bus.overrun), 64'h1);
        tick();
        check("bp_data_stable", 64'(bus.data_out), 64'hFFFFFE);
        do_reset();
        check("bp_overrun_rst", 64'(bus.overrun), 64'h0);

        // Simultaneous transfer and completion
        send_bits(24'h111111, 24, 1'b0, 1'b0);
        send_bits(24'h222222, 24, 1'b0, 1'b1);
        check("sim_valid", 64'(bus.out_valid), 64'h1);
        check("sim_data", 64'(bus.data_out), 64'h222222);
        check("sim_overrun", 64'(bus.overrun), 64'h0);
        tick();
        check("sim_valid_clear", 64'(bus.out_valid), 64'h0);
        bus.out_ready = 1'b0;

        // Resync
        send_bits(24'h0002AA, 10, 1'b0, 1'b0);
        check("rs_cnt10", 64'(bus.bit_cnt), 64'd10);
        bus.frame_tgl = 1'b1;
        tick();
        send_bits(24'h0F0F0F, 24, 1'b0, 1'b0);
`ifdef SIPO_RESYNC_EN
        check("rs_frame_err", 64'(bus.frame_err), 64'h1);
        check("rs_data", 64'(bus.data_out), 64'h0F0F0F);
        check("rs_bit_cnt", 64'(bus.bit_cnt), 64'h0);
`else
        check("rs_frame_err", 64'(bus.frame_err), 64'h0);
        check("rs_data", 64'(bus.data_out), 64'h3C3EAA);
        check("rs_bit_cnt", 64'(bus.bit_cnt), 64'd10);
`endif
        check("rs_valid", 64'(bus.out_valid), 64'h1);

        // Reset mid-word
        bus.frame_tgl = 1'b0;
        do_reset();
        bus.out_ready = 1'b1;
        send_bits(24'hFFFFFF, 12, 1'b0, 1'b0);
        check("mid_cnt12", 64'(bus.bit_cnt), 64'd12);
        do_reset();
        check("mid_rst_data", 64'(bus.data_out), 64'h0);
        check("mid_rst_valid", 64'(bus.out_valid), 64'h0);
        check("mid_rst_overrun", 64'(bus.overrun), 64'h0);
        check("mid_rst_frame_err", 64'(bus.frame_err), 64'h0);
        check("mid_rst_bit_cnt", 64'(bus.bit_cnt), 64'h0);
        send_bits(24'hABCDEF, 24, 1'b0, 1'b0);
        check("mid_data", 64'(bus.data_out), 64'hABCDEF);
        check("mid_valid", 64'(bus.out_valid), 64'h1);
        check("mid_overrun", 64'(bus.overrun), 64'h0);
        check("mid_frame_err", 64'(bus.frame_err), 64'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sipo_status_rx.md
# sipo_status_rx

Serial-in/parallel-out receiver that reassembles the status word from the quadrature-motor serial status link. It samples the serial data line on each bit strobe and rebuilds the word LSB-first. Each completed word is presented on a valid/ready output port with an overrun flag. It sits at the far end of the link, opposite the status serializer, and feeds the host-side register bank.

## Interface
- `WIDTH`, 24, status word length in bits (2..63)
- `sys_clk` in 1: single clock. All state updates on the rising edge; the serializer drives on the falling edge.
- `rst` in 1: synchronous, active-high reset.
- `serial_in` in 1: serial data bit.
- `bit_valid` in 1: strobe; `serial_in` is valid this cycle.
- `frame_tgl` in 1: frame toggle. The level flips once per transmitted frame.
- `out_ready` in 1: consumer accepts `data_out`.
- `data_out` out WIDTH: last completed word.
- `out_valid` out 1: `data_out` holds an unconsumed word.
- `overrun` out 1: sticky. An unconsumed word was overwritten.
- `frame_err` out 1: sticky. A partial word was discarded by resync.
- `bit_cnt` out $clog2(WIDTH+1): bits captured in the current word (debug).

## Operation
**Reset.** `rst`=1 at a rising edge clears the following:
- `bit_cnt` is 0 and the shift register is 0.
- `data_out` is 0.
- `out_valid`, `overrun` and `frame_err` are 0.
- The internal `frame_tgl_q` is 0.

A partial word in progress is discarded with no flags set.

**Capture.** When `bit_valid`=1, `serial_in` is stored at index `bit_cnt`, so bit i lands in position i, LSB first. `bit_cnt` then increments. With `bit_valid`=0, nothing changes; gaps of any length are allowed.

**Completion.** The edge that captures index WIDTH-1 does three things:
- loads `data_out` with the full word, including the bit captured on that edge;
- sets `out_valid`=1;
- resets `bit_cnt` to 0.

**Output handshake.** A transfer occurs on a rising edge with `out_valid`=1 and `out_ready`=1. After a transfer, `out_valid` clears unless a new word completes on that same edge. `data_out` is stable while `out_valid`=1 and no completion occurs.
- Completion with `out_valid`=1 and `out_ready`=0: `data_out` is overwritten with the new word, `out_valid` stays 1, and `overrun` is set.
- Completion on the same edge as a transfer: the old word counts as consumed, the new word is loaded, `out_valid` stays 1, and `overrun` is not set.
- `overrun` and `frame_err` clear only on `rst`.

**State machine.** Two states, encoded by `out_valid`:
- EMPTY → FULL on completion.
- FULL → EMPTY on a transfer with no completion.
- FULL → FULL on a completion, with or without a transfer.

## Timing
- Latency: `out_valid` and the new `data_out` are visible in the cycle after the edge that samples bit WIDTH-1.
- Minimum word period is WIDTH cycles; back-to-back words need no idle cycle.
- `out_ready` has no combinational path to any output.
- `frame_tgl` is sampled at the rising edge. A toggle edge is defined as `frame_tgl` ≠ `frame_tgl_q`, and `frame_tgl_q` updates every cycle.

## Configuration
`SIPO_RESYNC_EN` defined (frame resync active):
- On a toggle edge, the partial word is discarded and `bit_cnt` is forced to 0.
- If `bit_cnt` was nonzero at that edge, `frame_err` is set.
- If `bit_valid`=1 on the same edge, its bit is stored as index 0 and `bit_cnt`=1. The toggle edge takes priority over completion: index WIDTH-1 captured on a toggle edge does not complete a word.

`SIPO_RESYNC_EN` undefined:
- `frame_tgl` is ignored, `frame_tgl_q` is not built, and `frame_err` is tied to 0.
- Framing relies solely on counting `bit_valid` pulses from reset.

## Test plan
- **Basic word.** Reset, then 24 consecutive `bit_valid` cycles carrying 0xA5C3F0 LSB-first, with `out_ready`=1. Required: `data_out`=0xA5C3F0; `out_valid` high for exactly 1 cycle, starting the cycle after bit 23; `bit_cnt` back to 0.
- **Gapped strobe.** Send 0x123456 with `bit_valid` deasserted for 3 cycles after every 5th bit. Required: `data_out`=0x123456 and `out_valid` asserts once.
- **Backpressure.** Hold `out_ready`=0 and send 0x000001 then 0xFFFFFE. Required: `data_out`=0xFFFFFE, `out_valid`=1, `overrun`=1. Then pulse `out_ready` for 1 cycle. Required: `out_valid`=0 and `overrun` stays 1.
- **Simultaneous transfer and completion.** `out_ready` rises on the edge that captures bit 23 of the second word. Required: `out_valid` stays 1, `data_out` is the second word, `overrun`=0.
- **Resync (`SIPO_RESYNC_EN`).** Send 10 bits, toggle `frame_tgl`, then send 0x0F0F0F. Required: `frame_err`=1 and `data_out`=0x0F0F0F. Without the macro, the same stimulus yields a misaligned word and `frame_err`=0.
- **Reset mid-word.** Assert `rst` after 12 bits, then send 0xABCDEF. Required: all outputs 0 after reset, then `data_out`=0xABCDEF with no flags set.
